// File: rtl/matrix_add_set_sequencer_pkg.sv
// matrix_add_set_sequencer_pkg: shared state enum, width helper and default timing constants
package matrix_add_set_sequencer_pkg;
    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;
    localparam int DEF_MAX_SETS = 16;
    localparam int DEF_MEM_LAT = 1;
    localparam int DEF_TIMEOUT = 64;
    function automatic int set_w(input int n);
        return n > 1 ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/matrix_add_set_sequencer_if.sv
// matrix_add_set_sequencer_if: host, operand-read, adder-handshake and result-write signals
interface matrix_add_set_sequencer_if
    import matrix_add_set_sequencer_pkg::*;
    #(parameter int SET_W = set_w(DEF_MAX_SETS));
    logic start;
    logic abort;
    logic [SET_W-1:0] cfg_num_sets_m1;
    logic busy;
    logic done;
    logic error;
    logic rd_en;
    logic [SET_W-1:0] rd_set;
    logic adder_in_ready;
    logic adder_set_in_no;
    logic adder_out_ready;
    logic wr_en;
    logic [SET_W-1:0] wr_set;
    modport master (
        input start, abort, cfg_num_sets_m1, adder_out_ready,
        output busy, done, error, rd_en, rd_set, adder_in_ready, adder_set_in_no, wr_en, wr_set
    );
    modport slave (
        output start, abort, cfg_num_sets_m1, adder_out_ready,
        input busy, done, error, rd_en, rd_set, adder_in_ready, adder_set_in_no, wr_en, wr_set
    );
endinterface

// File: rtl/matrix_add_set_sequencer_set_valid_delay_line.sv
// set_valid_delay_line: STAGES-deep valid shift register with enable and synchronous clear
module set_valid_delay_line #(
    parameter int STAGES = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic clr,
    input  logic d,
    output logic q
);
    logic [STAGES-1:0] sr;
    always_ff @(posedge clk) begin
        if (reset || clr) begin
            sr <= '0;
        end else if (en) begin
            sr[0] <= d;
            for (int i = 1; i < STAGES; i++) sr[i] <= sr[i-1];
        end
    end
    assign q = sr[STAGES-1];
endmodule

// File: rtl/matrix_add_set_sequencer.sv
// matrix_add_set_sequencer: streams one matrix-add job through the adder, one vector set per cycle
module matrix_add_set_sequencer
    import matrix_add_set_sequencer_pkg::*;
#(
    parameter int MAX_SETS = DEF_MAX_SETS,
    parameter int SET_W = set_w(MAX_SETS),
    parameter int MEM_LAT = DEF_MEM_LAT,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input logic clk,
    input logic reset,
    input logic enable,
    matrix_add_set_sequencer_if.master bus
);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);
    state_t state;
    logic [SET_W:0] n, res_cnt, outstanding;
    logic [SET_W-1:0] rd_set_q;
    logic [TW-1:0] tmo_cnt;
    logic rd_q, done_q, err_q, sin_q, dl_q, valid, tmo_hit, kill, last_wr;
    // a result is legal only if some set is pending, counting this cycle's adder input
    assign valid = bus.adder_out_ready && (outstanding != '0 || dl_q);
    assign tmo_hit = outstanding != '0 && !bus.adder_out_ready && tmo_cnt == TMO_LAST;
    assign kill = enable && state != IDLE && (bus.abort || tmo_hit);
    assign last_wr = state == DRAIN && valid && res_cnt + 1'b1 == n;
    set_valid_delay_line #(.STAGES(MEM_LAT)) u_dl (
        .clk(clk), .reset(reset), .en(enable), .clr(kill), .d(rd_q), .q(dl_q)
    );
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            n <= '0;
            res_cnt <= '0;
            outstanding <= '0;
            tmo_cnt <= '0;
            rd_q <= 1'b0;
            rd_set_q <= '0;
            done_q <= 1'b0;
            err_q <= 1'b0;
            sin_q <= 1'b0;
        end else if (enable) begin
            done_q <= last_wr && !kill;
            err_q <= tmo_hit;
            sin_q <= sin_q ^ dl_q;
            if (kill) begin
                state <= IDLE;
                rd_q <= 1'b0;
                res_cnt <= '0;
                outstanding <= '0;
                tmo_cnt <= '0;
            end else begin
                outstanding <= dl_q && !valid ? outstanding + 1'b1 :
                               !dl_q && valid ? outstanding - 1'b1 : outstanding;
                tmo_cnt <= outstanding == '0 || bus.adder_out_ready ? '0 : tmo_cnt + 1'b1;
                if (valid) res_cnt <= res_cnt + 1'b1;
                case (state)
                    IDLE: if (bus.start) begin
                        state <= ISSUE;
                        n <= {1'b0, bus.cfg_num_sets_m1} + 1'b1;
                        rd_q <= 1'b1;
                        rd_set_q <= '0;
                        res_cnt <= '0;
                    end
                    ISSUE: if ({1'b0, rd_set_q} + 1'b1 == n) begin
                        state <= DRAIN;
                        rd_q <= 1'b0;
                    end else begin
                        rd_set_q <= rd_set_q + 1'b1;
                    end
                    DRAIN: if (last_wr) state <= IDLE;
                    default: state <= IDLE;
                endcase
            end
        end
    end
    assign bus.busy = state != IDLE;
    assign bus.done = enable && done_q;
    assign bus.error = enable && (err_q || (bus.adder_out_ready && !valid));
    assign bus.rd_en = enable && rd_q;
    assign bus.rd_set = rd_set_q;
    assign bus.adder_in_ready = enable && dl_q;
    assign bus.adder_set_in_no = sin_q;
    assign bus.wr_en = enable && valid;
    assign bus.wr_set = res_cnt[SET_W-1:0];
endmodule

// File: tb/tb_matrix_add_set_sequencer.sv
// tb_matrix_add_set_sequencer: directed per-cycle vectors against a 2-cycle adder model
module tb_matrix_add_set_sequencer;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic enable = 1'b1;
    logic p0 = 1'b0, p1 = 1'b0, mute = 1'b0, spur = 1'b0;
    logic sin_exp = 1'b0;
    int n_chk = 0;
    int n_fail = 0;
    always #5 clk = ~clk;
    matrix_add_set_sequencer_if #(.SET_W(4)) bus();
    matrix_add_set_sequencer #(.MAX_SETS(16), .SET_W(4), .MEM_LAT(1), .TIMEOUT(8)) dut (
        .clk(clk), .reset(reset), .enable(enable), .bus(bus.master)
    );
    // adder stand-in: result two enabled cycles after each input, frozen with enable
    always @(posedge clk) begin
        if (enable) begin
            p0 <= bus.adder_in_ready && !mute;
            p1 <= p0;
        end
    end
    assign bus.adder_out_ready = p1 || spur;
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask
    task automatic run(input string name, input int ncyc, input logic [3:0] cfg,
                       input logic [31:0] st, input logic [31:0] ab, input logic [31:0] en,
                       input logic [31:0] rs, input logic [31:0] sp,
                       input logic [31:0] e_rd, input logic [31:0] e_ir, input logic [31:0] e_wr,
                       input logic [31:0] e_done, input logic [31:0] e_busy, input logic [31:0] e_err);
        int rd_i = 0;
        int wr_i = 0;
        for (int c = 0; c < ncyc; c++) begin
            @(posedge clk);
            #1;
            bus.start = st[c];
            bus.abort = ab[c];
            enable = en[c];
            reset = rs[c];
            spur = sp[c];
            bus.cfg_num_sets_m1 = cfg;
            @(negedge clk);
            check($sformatf("%s.rd_en@%0d", name, c), 32'(bus.rd_en), 32'(e_rd[c]));
            check($sformatf("%s.in_ready@%0d", name, c), 32'(bus.adder_in_ready), 32'(e_ir[c]));
            check($sformatf("%s.wr_en@%0d", name, c), 32'(bus.wr_en), 32'(e_wr[c]));
            check($sformatf("%s.done@%0d", name, c), 32'(bus.done), 32'(e_done[c]));
            check($sformatf("%s.busy@%0d", name, c), 32'(bus.busy), 32'(e_busy[c]));
            check($sformatf("%s.error@%0d", name, c), 32'(bus.error), 32'(e_err[c]));
            check($sformatf("%s.set_in_no@%0d", name, c), 32'(bus.adder_set_in_no), 32'(sin_exp));
            if (e_rd[c]) begin
                check($sformatf("%s.rd_set@%0d", name, c), 32'(bus.rd_set), 32'(rd_i));
                rd_i++;
            end
            if (e_wr[c]) begin
                check($sformatf("%s.wr_set@%0d", name, c), 32'(bus.wr_set), 32'(wr_i));
                wr_i++;
            end
            if (st[c] && !e_busy[c]) begin
                rd_i = 0;
                wr_i = 0;
            end
            sin_exp = rs[c] ? 1'b0 : sin_exp ^ e_ir[c];
        end
    endtask
    initial begin
        bus.start = 1'b0;
        bus.abort = 1'b0;
        bus.cfg_num_sets_m1 = '0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        check("reset.busy", 32'(bus.busy), 0);
        check("reset.done", 32'(bus.done), 0);
        check("reset.error", 32'(bus.error), 0);
        check("reset.rd_en", 32'(bus.rd_en), 0);
        check("reset.rd_set", 32'(bus.rd_set), 0);
        check("reset.in_ready", 32'(bus.adder_in_ready), 0);
        check("reset.set_in_no", 32'(bus.adder_set_in_no), 0);
        check("reset.wr_en", 32'(bus.wr_en), 0);
        check("reset.wr_set", 32'(bus.wr_set), 0);
        // N=4 job; a second start while issuing is ignored
        run("basic", 10, 4'd3, 32'h9, 0, '1, 0, 0,
            32'h1E, 32'h3C, 32'hF0, 32'h100, 32'hFE, 0);
        // enable low in cycles 3-5 shifts everything after cycle 2 by three
        run("freeze", 13, 4'd3, 32'h1, 0, 32'hFFFF_FFC7, 0, 0,
            32'hC6, 32'h1C4, 32'h780, 32'h800, 32'h7FE, 0);
        // abort in cycle 5, late adder results flagged, clean restart at cycle 8
        run("abort", 18, 4'd3, 32'h101, 32'h20, '1, 0, 0,
            32'h1E1E, 32'h3C3C, 32'hF030, 32'h1_0000, 32'hFE3E, 32'hC0);
        mute = 1'b1;
        run("timeout", 13, 4'd3, 32'h1, 0, '1, 0, 0,
            32'h1E, 32'h3C, 0, 0, 32'h7FE, 32'h800);
        mute = 1'b0;
        // abort in IDLE ignored, spurious result in IDLE, then a single-set job
        run("spur_n1", 10, 4'd0, 32'h8, 32'h1, '1, 0, 32'h2,
            32'h10, 32'h20, 32'h80, 32'h100, 32'hF0, 32'h2);
        run("reset_drain", 10, 4'd3, 32'h1, 0, '1, 32'h20, 0,
            32'h1E, 32'h3C, 32'h30, 0, 32'h3E, 32'hC0);
        run("full16", 22, 4'd15, 32'h1, 0, '1, 0, 0,
            32'h1_FFFE, 32'h3_FFFC, 32'hF_FFF0, 32'h10_0000, 32'hF_FFFE, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/matrix_add_set_sequencer.md
Name: matrix_add_set_sequencer

Overview:
- Controller that streams one matrix-add job through the parallel-vector matrix adder, one vector set per cycle.
- Issues set reads to the A/B operand buffers and drives the adder's input handshake (inReady, vectorSetInNo).
- Tracks in-flight sets, steers adder results into the result buffer by set index, and reports done, error or abort to the host FSM.
- Sits between the operand/result buffer bank and the matrix adder instance; shares the adder's enable.

Parameters:
MAX_SETS, 16, largest number of vector sets per job
SET_W, $clog2(MAX_SETS), set-index width
MEM_LAT, 1, operand-buffer read latency in cycles (>=1)
TIMEOUT, 64, idle cycles allowed with sets outstanding before error

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
enable  in  1  global advance; same signal that feeds the adder's enable
start  in  1  one-cycle job request; sampled only in IDLE
abort  in  1  cancel current job
cfg_num_sets_m1  in  SET_W  sets in job minus one; latched on accepted start
busy  out  1  high from accepted start until return to IDLE
done  out  1  one-cycle pulse: job completed
error  out  1  one-cycle pulse: timeout or unexpected adder result
rd_en  out  1  operand-buffer read strobe
rd_set  out  SET_W  set index being read
adder_in_ready  out  1  drives adder inReady
adder_set_in_no  out  1  drives adder vectorSetInNo; toggles per issued set
adder_out_ready  in  1  adder outReady (per-set result valid)
wr_en  out  1  result-buffer write strobe (= adder_out_ready while in DRAIN/ISSUE)
wr_set  out  SET_W  destination set index for the current result

Behaviour:
- Reset: state=IDLE; busy, done, error, rd_en, adder_in_ready, wr_en = 0; rd_set = wr_set = 0; adder_set_in_no = 0. All counters and the delay line are cleared. A reset mid-job discards all in-flight sets and produces no done.
- enable=0 freezes the FSM, counters, delay line and timeout counter. Pulse outputs (rd_en, adder_in_ready, wr_en, done, error) are forced 0. They resume from the frozen state when enable returns to 1.
- States: IDLE -> ISSUE -> DRAIN -> IDLE.
- IDLE: on start=1, latch N=cfg_num_sets_m1+1, go to ISSUE and set busy=1. A start in any other state is ignored.
- ISSUE:
  - rd_en=1 every enabled cycle with rd_set = 0..N-1.
  - After rd_set=N-1 is issued, go to DRAIN.
  - The first rd_en occurs one cycle after start is accepted.
- Delay line:
  - rd_en is delayed by MEM_LAT to form adder_in_ready, so one adder_in_ready pulse follows each read by exactly MEM_LAT cycles.
  - adder_set_in_no toggles on each adder_in_ready.
- Outstanding count:
  - Width SET_W+1. Increments on adder_in_ready, decrements on adder_out_ready; both in the same cycle leaves it unchanged.
  - An adder_out_ready with outstanding=0 (nothing pending, counting this cycle's adder_in_ready) sets error=1 for that cycle. The write is suppressed and the count does not go negative.
- Writes: on a valid adder_out_ready, wr_en=1 with wr_set = result counter, then the result counter increments. Results are in order.
- DRAIN:
  - When the result counter reaches N in the same cycle as the final write, go to IDLE.
  - The next cycle, done=1 and busy=0.
- Timeout: while outstanding>0 and no adder_out_ready arrives for TIMEOUT consecutive enabled cycles, pulse error, return to IDLE with no done, and clear all counters.
- abort=1 in ISSUE or DRAIN: go to IDLE next cycle, busy=0, no done, delay line and counters cleared. abort in IDLE has no effect. abort takes priority over a same-cycle final write (no done).
- N=1 (cfg=0): single read, ISSUE lasts one cycle.
- N=MAX_SETS: rd_set reaches MAX_SETS-1 with no wrap, and the result counter is wide enough for N.

Decomposition:
- Shared package: state enum (IDLE/ISSUE/DRAIN), set-index width function, default MEM_LAT/TIMEOUT constants.
- One natural sub-module: set_valid_delay_line (parameterised MEM_LAT-stage shift register with synchronous clear and enable), reused for other buffer-latency alignment.

Test Plan:
- MEM_LAT=1, adder latency 2, cfg=3, start at cycle 0:
  - rd_en cycles 1-4 with rd_set 0..3; adder_in_ready cycles 2-5; wr_en cycles 4-7 with wr_set 0..3.
  - done at cycle 8; busy high for cycles 1-7.
- Same job with enable=0 for cycles 3-5: every event after cycle 2 shifts by 3 cycles; no pulse is asserted while enable=0; done at cycle 11.
- Abort at cycle 5 of the first scenario: busy=0 at cycle 6, no done, no further wr_en; a new start at cycle 8 runs cleanly from rd_set=0.
- Adder holds adder_out_ready low after inputs (TIMEOUT=8): error pulse 8 enabled cycles after the last progress, FSM back in IDLE, no done.
- Spurious adder_out_ready in IDLE: error pulses once, wr_en stays 0, outstanding stays 0. cfg=0 job: exactly one read and one write, done asserted.
- Reset asserted mid-DRAIN: all outputs 0 the next cycle, state IDLE; late adder_out_ready pulses are flagged as error.
